// File: rtl/hp_fifo_n.sv
// Host-to-parasite block FIFO: fills completely, then drains completely.
// Runtime one-entry mode, fill level, sticky overrun/underrun flags and synchronous flush.
module hp_fifo_n #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 2,
  parameter int unsigned LW         = $clog2(DEPTH + 1)
) (
  input  logic                  h_phi2,
  input  logic                  h_rst,
  input  logic                  h_we,
  input  logic [DATA_WIDTH-1:0] h_data,
  input  logic                  p_rd,
  output logic [DATA_WIDTH-1:0] p_data,
  input  logic                  one_byte_mode,
  input  logic                  flush,
  input  logic                  err_clr,
  output logic                  h_full,
  output logic                  p_data_available,
  output logic                  p_block_available,
  output logic [LW-1:0]         level,
  output logic                  h_overrun,
  output logic                  p_underrun
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  typedef enum logic {ST_FILL = 1'b0, ST_DRAIN = 1'b1} state_t;

  state_t                  state;
  logic [PW-1:0]           wr_ptr;
  logic [PW-1:0]           rd_ptr;
  logic [LW-1:0]           count;
  logic                    mode_q;
  logic [DATA_WIDTH-1:0]   mem [DEPTH];

  logic                    empty_fill;
  logic                    mode_eff;
  logic [LW-1:0]           cap;
  logic [LW-1:0]           count_inc;
  logic                    wr_ok;
  logic                    wr_rej;
  logic                    rd_ok;
  logic                    rd_rej;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : PW'(p + 1'b1);
  endfunction

  // The mode in force for a write landing in an empty filling FIFO is the live input
  assign empty_fill = (state == ST_FILL) && (count == '0);
  assign mode_eff   = empty_fill ? one_byte_mode : mode_q;
  assign cap        = mode_eff ? LW'(1) : DEPTH_L;
  assign count_inc  = LW'(count + 1'b1);

  assign wr_ok  = !flush && (state == ST_FILL)  && h_we;
  assign wr_rej = !flush && (state == ST_DRAIN) && h_we;
  assign rd_ok  = !flush && (state == ST_DRAIN) && p_rd;
  assign rd_rej = !flush && (state == ST_FILL)  && p_rd;

  assign level  = count;
  assign p_data = mem[rd_ptr];

  // Storage is deliberately not reset
  always_ff @(posedge h_phi2) begin
    if (!h_rst && wr_ok) begin
      mem[wr_ptr] <= h_data;
    end
  end

  always_ff @(posedge h_phi2) begin
    if (h_rst) begin
      state             <= ST_FILL;
      wr_ptr            <= '0;
      rd_ptr            <= '0;
      count             <= '0;
      mode_q            <= 1'b0;
      h_full            <= 1'b0;
      p_data_available  <= 1'b0;
      p_block_available <= 1'b0;
      h_overrun         <= 1'b0;
      p_underrun        <= 1'b0;
    end else begin
      // Sticky flags: a new error wins over a same-cycle clear
      h_overrun  <= (h_overrun  & ~err_clr) | wr_rej;
      p_underrun <= (p_underrun & ~err_clr) | rd_rej;

      if (flush) begin
        state             <= ST_FILL;
        wr_ptr            <= '0;
        rd_ptr            <= '0;
        count             <= '0;
        h_full            <= 1'b0;
        p_data_available  <= 1'b0;
        p_block_available <= 1'b0;
      end else begin
        if (empty_fill) begin
          mode_q <= one_byte_mode;
        end
        case (state)
          ST_FILL: begin
            if (wr_ok) begin
              wr_ptr <= ptr_inc(wr_ptr);
              count  <= count_inc;
              if (count_inc == cap) begin
                state             <= ST_DRAIN;
                h_full            <= 1'b1;
                p_data_available  <= 1'b1;
                p_block_available <= !mode_eff;
              end
            end
          end
          ST_DRAIN: begin
            if (rd_ok) begin
              rd_ptr            <= ptr_inc(rd_ptr);
              count             <= LW'(count - 1'b1);
              p_block_available <= 1'b0;
              if (count == LW'(1)) begin
                state            <= ST_FILL;
                h_full           <= 1'b0;
                p_data_available <= 1'b0;
              end
            end
          end
          default: state <= ST_FILL;
        endcase
      end
    end
  end

endmodule

// File: doc/hp_fifo_n.md
# hp_fifo_n

Parametrised host-to-parasite FIFO for Tube register-3 style block transfers. It generalises the fixed two-byte register to DEPTH entries of DATA_WIDTH bits, with runtime one-entry or block mode. It adds a fill level output, sticky overrun/underrun flags and a synchronous flush. Host writes and parasite reads are single-cycle strobes in one clock domain, and all status outputs are registered.

## Interface
Parameters:
- DATA_WIDTH, 8, entry width in bits
- DEPTH, 2, entries in block mode; legal values 2..256, power of two not required
- LW, derived as clog2(DEPTH+1), width of the level output

Ports:
- h_phi2  in  1  clock; all state updates on its rising edge
- h_rst  in  1  reset, synchronous, active-high
- h_we  in  1  host write strobe, one cycle per entry
- h_data  in  DATA_WIDTH  host write data
- p_rd  in  1  parasite read (pop) strobe, one cycle per entry
- p_data  out  DATA_WIDTH  head entry
- one_byte_mode  in  1  1 = capacity 1 (latch behaviour); 0 = block mode with capacity DEPTH
- flush  in  1  synchronous empty request
- err_clr  in  1  clears the sticky error flags
- h_full  out  1  host must not write
- p_data_available  out  1  parasite may read
- p_block_available  out  1  a complete untouched block is present (block mode only)
- level  out  LW  current entry count
- h_overrun  out  1  sticky: a write was rejected
- p_underrun  out  1  sticky: a read was rejected

## Operation
- Storage: DEPTH x DATA_WIDTH array, wr_ptr and rd_ptr, and a count register.
- Both pointers wrap from DEPTH-1 to 0. In one-entry mode, slots still rotate.
- mode_q latches one_byte_mode only while state=FILL and count=0. At all other times, mode changes are ignored until the FIFO is next empty. CAP = mode_q ? 1 : DEPTH.
- State machine:
  - FILL: accepts writes, rejects reads.
  - DRAIN: accepts reads, rejects writes.
- Transitions:
  - FILL->DRAIN when an accepted write makes count = CAP.
  - DRAIN->FILL when an accepted read makes count = 0.
  - No other transitions, so a partially drained block never accepts writes.
- Accepted write (FILL and h_we): store mem[wr_ptr] <= h_data, then wr_ptr+1 and count+1.
- Accepted read (DRAIN and p_rd): rd_ptr+1 and count-1.
- Rejected write: h_we in DRAIN. Storage, pointers and count are unchanged; h_overrun <= 1.
- Rejected read: p_rd in FILL. State is unchanged; p_underrun <= 1.
- Simultaneous h_we and p_rd: exactly one can be legal in any state. The illegal one is rejected and flagged; the legal one proceeds.
- Outputs:
  - h_full = p_data_available = (state == DRAIN).
  - p_block_available = DRAIN and !mode_q and count == DEPTH, so it drops after the first pop.
  - level = count.
  - p_data = mem[rd_ptr] at all times; its value is undefined when count = 0.
- Flush: pointers, count and state return to FILL with count 0. mode_q is re-sampled on the next cycle. Storage contents and error flags are untouched. Flush overrides h_we and p_rd in the same cycle, and those strobes are neither performed nor flagged.
- err_clr clears both sticky flags. If a new error occurs in the same cycle, the set wins.
- Priority: h_rst > flush > normal operation.

## Timing
- Reset values: state=FILL, count=0, pointers=0, mode_q=0 (block mode), h_full=0, p_data_available=0, p_block_available=0, level=0, h_overrun=0, p_underrun=0. Storage is not reset; p_data after reset is mem[0], which is undefined until written.
- Reset or flush asserted mid-block discards all entries, with outputs as above from the next cycle.
- Write in cycle N:
  - level increments at N+1.
  - If the write is the CAP-th entry, h_full and p_data_available go high at N+1.
  - p_data shows the first written entry from N+1.
- Read in cycle M:
  - p_data shows the next entry at M+1.
  - level decrements at M+1.
  - On the final read, h_full and p_data_available go low at M+1, and a write in M+1 is accepted.
- Back-to-back strobes sustain one entry per cycle in each direction.
- Minimum round trip is 2*CAP cycles: a block fills in CAP cycles and drains in CAP cycles.

## Test plan
- DEPTH=4, block mode: write A1,A2,A3,A4 on consecutive cycles.
  - h_full, p_data_available and p_block_available rise after the 4th write; level=4.
  - Pops return A1..A4 in order; p_block_available drops after the first pop; h_full drops after the 4th pop.
- one_byte_mode=1: write 0x55 -> h_full=1 and level=1. A second write sets h_overrun, and a pop still returns 0x55.
- Block mode, DEPTH=4, after 2 writes: assert p_rd -> p_underrun=1, level stays 2. A third write is still accepted.
- Wrap: DEPTH=3, run three full blocks of distinct data -> every pop is in order, pointers wrap, and level never exceeds 3.
- Flush with level=3 plus simultaneous h_we -> next cycle level=0, state=FILL, h_overrun unchanged. Mode toggled while level=2 is ignored until empty.
- Same cycle err_clr and rejected write -> h_overrun stays 1. err_clr alone -> both flags 0 next cycle. h_rst during DRAIN -> all outputs at reset values next cycle.
